// File: rtl/spi_ram_ctrl.sv
// Command-driven single-port RAM behind the SPI slave deserialiser.
// Address commands arm a write or read. Data commands are accepted only when armed; otherwise they raise seq_err.
module spi_ram_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter bit          AUTO_INC   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH+1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    output logic                  seq_err,
    output logic                  wr_armed,
    output logic                  rd_armed
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_ARMED = 2'd1,
        ST_RD_ARMED = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_tx_valid;
    logic                  r_seq_err;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [1:0]            w_cmd;
    logic [DATA_WIDTH-1:0] w_payload;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_wr_en;

    assign w_cmd     = din[DATA_WIDTH+1:DATA_WIDTH];
    assign w_payload = din[DATA_WIDTH-1:0];
    assign w_addr    = din[ADDR_WIDTH-1:0];
    assign w_wr_en   = rx_valid && (w_cmd == CMD_WR_DATA) && (r_state == ST_WR_ARMED);

    // Storage array: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_payload;
        end
    end

    // Sequencing FSM, pointers and registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_dout     <= '0;
            r_tx_valid <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            r_seq_err  <= 1'b0;
            if (rx_valid) begin
                case (w_cmd)
                    CMD_WR_ADDR: begin
                        r_wr_ptr <= w_addr;
                        r_state  <= ST_WR_ARMED;
                    end
                    CMD_RD_ADDR: begin
                        r_rd_ptr <= w_addr;
                        r_state  <= ST_RD_ARMED;
                    end
                    CMD_WR_DATA: begin
                        if (r_state == ST_WR_ARMED) begin
                            if (AUTO_INC) begin
                                r_wr_ptr <= ADDR_WIDTH'(r_wr_ptr + 1'b1);
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_seq_err <= 1'b1;
                        end
                    end
                    CMD_RD_DATA: begin
                        if (r_state == ST_RD_ARMED) begin
                            r_dout     <= r_mem[r_rd_ptr];
                            r_tx_valid <= 1'b1;
                            if (AUTO_INC) begin
                                r_rd_ptr <= ADDR_WIDTH'(r_rd_ptr + 1'b1);
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_seq_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign dout     = r_dout;
    assign tx_valid = r_tx_valid;
    assign seq_err  = r_seq_err;
    assign wr_armed = (r_state == ST_WR_ARMED);
    assign rd_armed = (r_state == ST_RD_ARMED);

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: index 0 is the single-shot instance and index 1 is the auto-increment instance.
// A command-level reference model predicts every output.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxv     [2];
    logic [9:0] din_w   [2];
    logic [7:0] dout_w  [2];
    logic       tx_w    [2];
    logic       err_w   [2];
    logic       wra_w   [2];
    logic       rda_w   [2];

    always #5 clk = ~clk;

    spi_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .AUTO_INC(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .rx_valid(rxv[0]), .din(din_w[0]), .dout(dout_w[0]),
        .tx_valid(tx_w[0]), .seq_err(err_w[0]), .wr_armed(wra_w[0]), .rd_armed(rda_w[0])
    );

    spi_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .AUTO_INC(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .rx_valid(rxv[1]), .din(din_w[1]), .dout(dout_w[1]),
        .tx_valid(tx_w[1]), .seq_err(err_w[1]), .wr_armed(wra_w[1]), .rd_armed(rda_w[1])
    );

    // Reference model: armed mode 0 = none, 1 = write, 2 = read.
    int         mode     [2];
    logic [7:0] wp       [2];
    logic [7:0] rp       [2];
    logic [7:0] mmem     [2][256];
    bit         mknown   [2][256];
    logic [7:0] e_dout   [2];
    bit         e_dknown [2];
    bit         e_tx     [2];
    bit         e_err    [2];

    int total = 0;
    int bad   = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mode[d] = 0; wp[d] = 8'h00; rp[d] = 8'h00;
            e_dout[d] = 8'h00; e_dknown[d] = 1'b1; e_tx[d] = 1'b0; e_err[d] = 1'b0;
        end
    endtask

    task automatic model_cmd(input int d, input logic [1:0] cmd, input logic [7:0] pl);
        e_tx[d]  = 1'b0;
        e_err[d] = 1'b0;
        case (cmd)
            2'b00: begin wp[d] = pl; mode[d] = 1; end
            2'b10: begin rp[d] = pl; mode[d] = 2; end
            2'b01: begin
                if (mode[d] == 1) begin
                    mmem[d][wp[d]] = pl;
                    mknown[d][wp[d]] = 1'b1;
                    if (d == 1) wp[d] = wp[d] + 8'd1;
                    else mode[d] = 0;
                end else begin
                    e_err[d] = 1'b1;
                end
            end
            default: begin
                if (mode[d] == 2) begin
                    e_dout[d]   = mmem[d][rp[d]];
                    e_dknown[d] = mknown[d][rp[d]];
                    e_tx[d]     = 1'b1;
                    if (d == 1) rp[d] = rp[d] + 8'd1;
                    else mode[d] = 0;
                end else begin
                    e_err[d] = 1'b1;
                end
            end
        endcase
    endtask

    // One command to instance d in the next cycle; returns 1 time unit after the sampling edge.
    task automatic do_cmd(input int d, input logic [1:0] cmd, input logic [7:0] pl);
        @(negedge clk);
        rxv[d]   = 1'b1;
        din_w[d] = {cmd, pl};
        @(posedge clk);
        #1;
        rxv[d] = 1'b0;
        model_cmd(d, cmd, pl);
        e_tx[1-d]  = 1'b0;
        e_err[1-d] = 1'b0;
    endtask

    task automatic do_idle();
        @(negedge clk);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            e_tx[d] = 1'b0; e_err[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++; if (dout_w[d] !== 8'h00) begin bad++; $display("FAIL por_dout[%0d]: got %h exp 00", d, dout_w[d]); end
            total++; if ({tx_w[d], err_w[d], wra_w[d], rda_w[d]} !== 4'b0000) begin
                bad++; $display("FAIL por_flags[%0d]: got tx/err/wra/rda=%b exp 0000", d, {tx_w[d], err_w[d], wra_w[d], rda_w[d]});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_cmd(0, 2'b00, 8'h30);
        do_cmd(0, 2'b01, 8'hA5);
        do_cmd(0, 2'b10, 8'h30);
        do_cmd(0, 2'b11, 8'h00);
        total++; if ({tx_w[0], dout_w[0]} !== {1'b1, 8'hA5}) begin
            bad++; $display("FAIL pre_reset_read: got tx=%b dout=%h exp tx=1 dout=a5", tx_w[0], dout_w[0]);
        end
        #1 rst = 1'b1;
        #1;
        total++; if (dout_w[0] !== 8'h00) begin bad++; $display("FAIL async_rst_dout: got %h exp 00", dout_w[0]); end
        total++; if ({tx_w[0], err_w[0], wra_w[0], rda_w[0]} !== 4'b0000) begin
            bad++; $display("FAIL async_rst_flags: got %b exp 0000", {tx_w[0], err_w[0], wra_w[0], rda_w[0]});
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_cmd(0, 2'b00, 8'h12);
        total++; if (wra_w[0] !== 1'b1) begin bad++; $display("FAIL single_wr_armed: got %b exp 1", wra_w[0]); end
        do_cmd(0, 2'b01, 8'h5A);
        total++; if (wra_w[0] !== 1'b0) begin bad++; $display("FAIL single_idle_after_wr: got wra=%b exp 0", wra_w[0]); end
        do_cmd(0, 2'b10, 8'h12);
        total++; if (rda_w[0] !== 1'b1) begin bad++; $display("FAIL single_rd_armed: got %b exp 1", rda_w[0]); end
        do_cmd(0, 2'b11, 8'h00);
        total++; if ({tx_w[0], dout_w[0], rda_w[0]} !== {1'b1, 8'h5A, 1'b0}) begin
            bad++; $display("FAIL single_read: got tx=%b dout=%h rda=%b exp tx=1 dout=5a rda=0", tx_w[0], dout_w[0], rda_w[0]);
        end
        do_idle();
        total++; if ({tx_w[0], dout_w[0]} !== {1'b0, 8'h5A}) begin
            bad++; $display("FAIL single_hold: got tx=%b dout=%h exp tx=0 dout=5a", tx_w[0], dout_w[0]);
        end
    endtask

    task automatic test_out_of_order();
        do_cmd(0, 2'b01, 8'h33);
        total++; if ({err_w[0], tx_w[0], wra_w[0]} !== 3'b100) begin
            bad++; $display("FAIL ooo_wr_data: got err/tx/wra=%b exp 100", {err_w[0], tx_w[0], wra_w[0]});
        end
        do_cmd(0, 2'b11, 8'h00);
        total++; if ({err_w[0], tx_w[0], dout_w[0]} !== {2'b10, 8'h5A}) begin
            bad++; $display("FAIL ooo_rd_data: got err=%b tx=%b dout=%h exp err=1 tx=0 dout=5a", err_w[0], tx_w[0], dout_w[0]);
        end
        do_idle();
        total++; if (err_w[0] !== 1'b0) begin bad++; $display("FAIL ooo_err_drop: got %b exp 0", err_w[0]); end
        do_cmd(0, 2'b10, 8'h12);
        do_cmd(0, 2'b11, 8'h00);
        total++; if (dout_w[0] !== 8'h5A) begin bad++; $display("FAIL ooo_mem_unchanged: got %h exp 5a", dout_w[0]); end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        do_cmd(1, 2'b00, 8'hFE);
        for (int i = 0; i < 3; i++) do_cmd(1, 2'b01, vals[i]);
        total++; if (wra_w[1] !== 1'b1) begin bad++; $display("FAIL burst_stay_armed: got %b exp 1", wra_w[1]); end
        do_cmd(1, 2'b10, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            do_cmd(1, 2'b11, 8'h00);
            total++; if ({tx_w[1], dout_w[1]} !== {1'b1, vals[i]}) begin
                bad++; $display("FAIL burst_read%0d: got tx=%b dout=%h exp tx=1 dout=%h", i, tx_w[1], dout_w[1], vals[i]);
            end
        end
        do_idle();
        total++; if ({tx_w[1], dout_w[1]} !== {1'b0, 8'h33}) begin
            bad++; $display("FAIL burst_tx_drop: got tx=%b dout=%h exp tx=0 dout=33", tx_w[1], dout_w[1]);
        end
    endtask

    task automatic test_arm_override();
        do_cmd(0, 2'b00, 8'h04);
        do_cmd(0, 2'b01, 8'h99);
        do_cmd(0, 2'b00, 8'h04);
        do_cmd(0, 2'b10, 8'h04);
        do_cmd(0, 2'b01, 8'h77);
        total++; if ({err_w[0], rda_w[0], wra_w[0]} !== 3'b110) begin
            bad++; $display("FAIL override_flags: got err/rda/wra=%b exp 110", {err_w[0], rda_w[0], wra_w[0]});
        end
        do_cmd(0, 2'b11, 8'h00);
        total++; if ({tx_w[0], dout_w[0]} !== {1'b1, 8'h99}) begin
            bad++; $display("FAIL override_mem: got tx=%b dout=%h exp tx=1 dout=99", tx_w[0], dout_w[0]);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] exp_rd [3];
        exp_rd[0] = 8'hC1; exp_rd[1] = 8'hC2; exp_rd[2] = 8'h5C;
        do_cmd(1, 2'b00, 8'h42);
        do_cmd(1, 2'b01, 8'h5C);
        do_cmd(1, 2'b00, 8'h40);
        do_cmd(1, 2'b01, 8'hC1);
        do_cmd(1, 2'b01, 8'hC2);
        #1 rst = 1'b1;
        #1 model_reset();
        @(negedge clk);
        rst = 1'b0;
        do_cmd(1, 2'b01, 8'hC3);
        total++; if ({err_w[1], tx_w[1], wra_w[1]} !== 3'b100) begin
            bad++; $display("FAIL midrst_seq_err: got err/tx/wra=%b exp 100", {err_w[1], tx_w[1], wra_w[1]});
        end
        total++; if (u_dut1.r_wr_ptr !== 8'h00) begin bad++; $display("FAIL midrst_wr_ptr: got %h exp 00", u_dut1.r_wr_ptr); end
        do_cmd(1, 2'b10, 8'h40);
        for (int i = 0; i < 3; i++) begin
            do_cmd(1, 2'b11, 8'h00);
            total++; if ({tx_w[1], dout_w[1]} !== {1'b1, exp_rd[i]}) begin
                bad++; $display("FAIL midrst_read%0d: got tx=%b dout=%h exp tx=1 dout=%h", i, tx_w[1], dout_w[1], exp_rd[i]);
            end
        end
    endtask

    task automatic test_random();
        int         d;
        logic [1:0] cmd;
        logic [7:0] pl;
        for (int n = 0; n < 600; n++) begin
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                do_idle();
            end else begin
                cmd = 2'($urandom_range(0, 3));
                if (cmd[0] == 1'b0) begin
                    pl = 8'($urandom_range(0, 15));
                    if ($urandom_range(0, 3) == 0) pl = pl | 8'hF0;
                end else begin
                    pl = 8'($urandom);
                end
                do_cmd(d, cmd, pl);
            end
            for (int k = 0; k < 2; k++) begin
                total++;
                if ({tx_w[k], err_w[k], wra_w[k], rda_w[k]} !== {e_tx[k], e_err[k], mode[k] == 1, mode[k] == 2}) begin
                    bad++;
                    $display("FAIL rand_flags[%0d] step %0d: got tx/err/wra/rda=%b exp %b", k, n,
                             {tx_w[k], err_w[k], wra_w[k], rda_w[k]}, {e_tx[k], e_err[k], mode[k] == 1, mode[k] == 2});
                end
                if (e_dknown[k]) begin
                    total++;
                    if (dout_w[k] !== e_dout[k]) begin
                        bad++; $display("FAIL rand_dout[%0d] step %0d: got %h exp %h", k, n, dout_w[k], e_dout[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        rxv[0] = 1'b0; rxv[1] = 1'b0;
        din_w[0] = '0; din_w[1] = '0;
        rst = 1'b1;
        model_reset();
        test_reset();
        test_single();
        test_out_of_order();
        test_burst_wrap();
        test_arm_override();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
